// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap controller:
//   - FSM state encoding used by trap_ctrl
//   - mcause exception / interrupt codes
//   - position of the interrupt flag inside mcause
// Optional feature macro (used by the importing modules):
//   TRAP_CTRL_TIMER_IRQ_EN - enables the machine timer interrupt path.
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RET   = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_e;

    localparam int unsigned CAUSE_ECALL_M      = 11;
    localparam int unsigned CAUSE_BREAKPOINT   = 3;
    localparam int unsigned CAUSE_M_TIMER_IRQ  = 7;

    // The interrupt flag of mcause is always its most significant bit.
    function automatic int unsigned irq_bit_pos(input int unsigned xlen);
        return xlen - 1;
    endfunction

endpackage : trap_ctrl_pkg

// File: rtl/trap_ctrl_cause_enc.sv
// -----------------------------------------------------------------------------
// trap_cause_enc
// Combinational priority encoder for the retiring instruction's trap class.
// Priority: timer interrupt > ecall > ebreak > mret.
// Ports:
//   clint_mtip, csr_mie_mtie, csr_mstatus_mie : timer interrupt qualifiers
//   inst_ecall, inst_ebreak, inst_mret        : decoded instruction class
//   take    : a trap (interrupt or exception) must be entered
//   cause   : mcause value for the trap, valid with take
//   is_ret  : mret with no higher-priority event
// Optional feature macro:
//   TRAP_CTRL_TIMER_IRQ_EN - when undefined the interrupt qualifiers are
//   ignored and no interrupt is ever taken.
// -----------------------------------------------------------------------------
module trap_cause_enc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clint_mtip,
    input  logic            csr_mie_mtie,
    input  logic            csr_mstatus_mie,
    input  logic            inst_ecall,
    input  logic            inst_ebreak,
    input  logic            inst_mret,
    output logic            take,
    output logic [XLEN-1:0] cause,
    output logic            is_ret
);

    localparam int unsigned     IRQ_BIT  = irq_bit_pos(XLEN);
    localparam logic [XLEN-1:0] IRQ_FLAG = XLEN'(1) << IRQ_BIT;

    logic irq_take;

`ifdef TRAP_CTRL_TIMER_IRQ_EN
    assign irq_take = clint_mtip & csr_mie_mtie & csr_mstatus_mie;
`else
    // Interrupt path compiled out; the qualifier ports stay for a stable interface.
    logic unused_irq_inputs;
    assign unused_irq_inputs = clint_mtip ^ csr_mie_mtie ^ csr_mstatus_mie;
    assign irq_take          = 1'b0;
`endif

    always_comb begin
        take   = 1'b0;
        is_ret = 1'b0;
        cause  = '0;
        if (irq_take) begin
            take  = 1'b1;
            cause = IRQ_FLAG | XLEN'(CAUSE_M_TIMER_IRQ);
        end else if (inst_ecall) begin
            take  = 1'b1;
            cause = XLEN'(CAUSE_ECALL_M);
        end else if (inst_ebreak) begin
            take  = 1'b1;
            cause = XLEN'(CAUSE_BREAKPOINT);
        end else if (inst_mret) begin
            is_ret = 1'b1;
        end
    end

endmodule : trap_cause_enc

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap entry / mret sequencer. Watches retiring instructions,
// strobes the CSR unit for trap entry or mret, then issues a valid/ready
// redirect to fetch. The pipeline is stalled (busy) while a sequence runs.
// Ports:
//   clk, rst (sync, active-low)
//   inst_valid, inst_addr, inst_ecall, inst_ebreak, inst_mret : retiring insn
//   clint_mtip, csr_mstatus_mie, csr_mie_mtie                 : timer irq
//   csr_mtvec, csr_mepc                                       : redirect targets
//   trap_en, trap_cause, trap_epc                             : trap entry strobe
//   ret_en                                                    : mret strobe
//   redirect_valid, redirect_pc, redirect_ready               : fetch redirect
//   busy                                                      : stall request
// Optional feature macro:
//   TRAP_CTRL_TIMER_IRQ_EN - enables the timer interrupt path (see trap_cause_enc).
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_addr,
    input  logic            inst_ecall,
    input  logic            inst_ebreak,
    input  logic            inst_mret,
    input  logic            clint_mtip,
    input  logic            csr_mstatus_mie,
    input  logic            csr_mie_mtie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            trap_en,
    output logic            ret_en,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    logic            enc_take;
    logic            enc_is_ret;
    logic [XLEN-1:0] enc_cause;

    trap_cause_enc #(
        .XLEN (XLEN)
    ) u_cause_enc (
        .clint_mtip      (clint_mtip),
        .csr_mie_mtie    (csr_mie_mtie),
        .csr_mstatus_mie (csr_mstatus_mie),
        .inst_ecall      (inst_ecall),
        .inst_ebreak     (inst_ebreak),
        .inst_mret       (inst_mret),
        .take            (enc_take),
        .cause           (enc_cause),
        .is_ret          (enc_is_ret)
    );

    trap_state_e     state_q, state_d;
    logic            trap_en_q, trap_en_d;
    logic            ret_en_q, ret_en_d;
    logic [XLEN-1:0] trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            busy_q, busy_d;

    // All outputs are registered: the next-state decision also sets up the
    // outputs of the state being entered, so strobes land exactly in that state.
    always_comb begin
        state_d          = state_q;
        trap_en_d        = 1'b0;
        ret_en_d         = 1'b0;
        trap_cause_d     = '0;
        trap_epc_d       = '0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        case (state_q)
            ST_IDLE: begin
                // Events (including interrupts) are only sampled with a retiring insn.
                if (inst_valid) begin
                    if (enc_take) begin
                        state_d      = ST_ENTER;
                        trap_en_d    = 1'b1;
                        trap_cause_d = enc_cause;
                        trap_epc_d   = inst_addr;
                    end else if (enc_is_ret) begin
                        state_d  = ST_RET;
                        ret_en_d = 1'b1;
                    end
                end
            end
            ST_ENTER: begin
                state_d          = ST_REDIR;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = csr_mtvec;
            end
            ST_RET: begin
                state_d          = ST_REDIR;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = csr_mepc;
            end
            ST_REDIR: begin
                // Hold valid and pc until fetch accepts the redirect.
                if (redirect_ready) begin
                    state_d          = ST_IDLE;
                    redirect_valid_d = 1'b0;
                    redirect_pc_d    = '0;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                redirect_valid_d = 1'b0;
                redirect_pc_d    = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            trap_en_q        <= 1'b0;
            ret_en_q         <= 1'b0;
            trap_cause_q     <= '0;
            trap_epc_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            trap_en_q        <= trap_en_d;
            ret_en_q         <= ret_en_d;
            trap_cause_q     <= trap_cause_d;
            trap_epc_q       <= trap_epc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= busy_d;
        end
    end

    assign trap_en        = trap_en_q;
    assign ret_en         = ret_en_q;
    assign trap_cause     = trap_cause_q;
    assign trap_epc       = trap_epc_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = busy_q;

endmodule : trap_ctrl

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter XLEN, default 64, data and address width of all CSR and PC ports.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous active-low reset; the block is in reset while rst==0 at a rising edge.
REQ-004 inst_valid  in  1  retiring instruction presented this cycle.
REQ-005 inst_addr  in  XLEN  PC of the retiring instruction.
REQ-006 inst_ecall / inst_ebreak / inst_mret  in  1 each  decoded class of the retiring instruction.
REQ-007 clint_mtip  in  1  timer interrupt pending from CLINT, level.
REQ-008 csr_mstatus_mie, csr_mie_mtie  in  1 each  current mstatus[3] and mie[7].
REQ-009 csr_mtvec, csr_mepc  in  XLEN  current mtvec and mepc values.
REQ-010 trap_en  out  1  one-cycle strobe: CSR unit performs trap entry.
REQ-011 ret_en  out  1  one-cycle strobe: CSR unit performs mret.
REQ-012 trap_cause  out  XLEN  mcause write value, valid with trap_en.
REQ-013 trap_epc  out  XLEN  mepc write value, valid with trap_en.
REQ-014 redirect_valid  out  1, redirect_pc  out  XLEN, redirect_ready  in  1  valid/ready redirect to fetch.
REQ-015 busy  out  1  stall request to pipeline; high in every non-IDLE state.

Function
REQ-016 FSM states IDLE, ENTER, RET, REDIR; one-hot or binary encoding at implementer's choice.
REQ-017 IDLE, inst_valid=1: irq_take = clint_mtip & csr_mie_mtie & csr_mstatus_mie; priority irq_take > ecall > ebreak > mret.
REQ-018 irq_take -> latch cause = bit XLEN-1 set | 7, epc = inst_addr; go ENTER.
REQ-019 ecall -> cause 11; ebreak -> cause 3; epc = inst_addr; go ENTER.
REQ-020 mret (no higher-priority event) -> go RET; none of the above -> stay IDLE.
REQ-021 inst_valid=0 in IDLE: no action; interrupts are only sampled with inst_valid.
REQ-022 ENTER: trap_en=1 for exactly this cycle with latched cause/epc; latch redirect_pc=csr_mtvec; go REDIR.
REQ-023 RET: ret_en=1 for exactly this cycle; latch redirect_pc=csr_mepc; go REDIR.
REQ-024 REDIR: redirect_valid=1, redirect_pc stable; on redirect_ready=1 go IDLE the next cycle; redirect_valid never drops without handshake.
REQ-025 Latency: event accepted at edge N -> trap_en/ret_en in cycle N+1 -> redirect_valid from cycle N+2.
REQ-026 busy=0 only in IDLE; inst_valid and all event inputs ignored while busy=1.
REQ-027 trap_en and ret_en never assert in the same cycle; trap_cause/trap_epc read 0 outside ENTER.

Reset
REQ-028 rst==0 at an edge forces IDLE from any state, aborting pending redirect; all outputs 0 next cycle: trap_en, ret_en, redirect_valid, busy, trap_cause, trap_epc, redirect_pc.

Configuration
REQ-029 Macro TRAP_CTRL_TIMER_IRQ_EN: defined -> REQ-017/018 interrupt path active; undefined -> irq_take tied 0, clint_mtip/csr_mie_mtie/csr_mstatus_mie ignored, ports retained.

Structure
REQ-030 Cause codes (11, 3, interrupt 7), interrupt bit position and FSM state encodings live in the shared defines file.
REQ-031 Sub-module trap_cause_enc: combinational priority encoder producing take/cause/is_ret from decoded inputs; FSM and latches stay in trap_ctrl.

Verification
REQ-032 ecall at inst_addr 0x8000_0010, mtvec 0x8000_0100, ready=1 -> trap_en cycle+1 with cause 11, epc 0x8000_0010; redirect_pc 0x8000_0100 cycle+2; IDLE cycle+3.
REQ-033 mret, mepc 0x8000_0014, ready held 0 for 3 cycles -> ret_en one cycle; redirect_valid high 3+ cycles, pc stable 0x8000_0014 until handshake.
REQ-034 ecall with mtip=1, mie_mtie=1, mstatus_mie=1 -> cause 0x8000_0000_0000_0007 (XLEN 64); macro undefined -> cause 11.
REQ-035 mtip=1 with mstatus_mie=0 -> no trap; busy stays 0.
REQ-036 rst=0 asserted in REDIR -> next cycle IDLE, redirect_valid=0; ebreak during busy -> ignored, no second trap_en.
